// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrating mux with valid/ready handshakes and a registered output
module rr_arb_mux #(
   parameter int WIDTH   = 32,
   parameter int NUM_CH  = 4,
   parameter int RR_MODE = 1,
   parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       W_in_valid,
   input  logic [NUM_CH*WIDTH-1:0] W_in_data,
   output logic [NUM_CH-1:0]       W_in_ready,
   output logic                    W_out_valid,
   output logic [WIDTH-1:0]        W_out_data,
   output logic [CH_W-1:0]         W_out_ch,
   input  logic                    W_out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [CH_W-1:0]  out_ch_q,    out_ch_d;
   logic [CH_W-1:0]  ptr_q,       ptr_d;

   logic             can_accept;
   logic             grant_vld;
   logic [CH_W-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             xfer;

   // A full register that is being drained this cycle may be refilled in the same cycle
   assign can_accept = ~out_valid_q | W_out_ready;
   assign xfer       = grant_vld & can_accept;

   // Grant search: first pass covers channels at or above the pointer, second pass wraps to 0
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!grant_vld && W_in_valid[i] && ((RR_MODE == 0) || (i >= int'(ptr_q)))) begin
            grant_vld = 1'b1;
            grant_idx = CH_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!grant_vld && W_in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = CH_W'(i);
         end
      end
   end

   // Select granted data only, so non-granted (possibly X) channels never reach the register
   always_comb begin
      grant_data = '0;
      W_in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_vld && (grant_idx == CH_W'(i))) begin
            grant_data    = W_in_data[i*WIDTH +: WIDTH];
            W_in_ready[i] = can_accept;
         end
      end
   end

   // Next state of the output stage and the round-robin pointer
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_ch_d    = grant_idx;
         if (RR_MODE != 0) begin
            ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
         end
      end else if (W_out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset drops any held item immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign W_out_valid = out_valid_q;
   assign W_out_data  = out_data_q;
   assign W_out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - self-checking bench for rr_arb_mux (round-robin and fixed-priority instances)
module tb_rr_arb_mux;

   localparam int W = 32;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic           out_ready;

   logic [N-1:0] o_ready [2];
   logic         o_valid [2];
   logic [W-1:0] o_data  [2];
   logic [1:0]   o_ch    [2];

   int checks = 0;
   int errors = 0;

   // instance 0 = round-robin, instance 1 = fixed priority
   logic         m_valid [2];
   logic [W-1:0] m_data  [2];
   int           m_ch    [2];
   int           m_ptr   [2];

   always #5 clk = ~clk;

   rr_arb_mux #(.WIDTH(W), .NUM_CH(N), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst),
      .W_in_valid(in_valid), .W_in_data(in_data), .W_in_ready(o_ready[0]),
      .W_out_valid(o_valid[0]), .W_out_data(o_data[0]), .W_out_ch(o_ch[0]),
      .W_out_ready(out_ready)
   );

   rr_arb_mux #(.WIDTH(W), .NUM_CH(N), .RR_MODE(0)) u_fp (
      .clk(clk), .rst(rst),
      .W_in_valid(in_valid), .W_in_data(in_data), .W_in_ready(o_ready[1]),
      .W_out_valid(o_valid[1]), .W_out_data(o_data[1]), .W_out_ch(o_ch[1]),
      .W_out_ready(out_ready)
   );

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
      end
   endtask

   // Search order: from the pointer (RR) or from 0 (fixed), wrapping around the channel list
   function automatic int mgrant(input int d);
      int start;
      start = (d == 0) ? m_ptr[0] : 0;
      for (int k = 0; k < N; k++) begin
         if (in_valid[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] mready(input int d);
      logic [N-1:0] r;
      int g;
      r = '0;
      g = mgrant(d);
      if (g >= 0 && (!m_valid[d] || out_ready)) r[g] = 1'b1;
      return r;
   endfunction

   // Reference model state update
   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_valid[d] <= 1'b0;
            m_data[d]  <= '0;
            m_ch[d]    <= 0;
            m_ptr[d]   <= 0;
         end else if (mready(d) != '0) begin
            m_valid[d] <= 1'b1;
            m_data[d]  <= in_data[mgrant(d)*W +: W];
            m_ch[d]    <= mgrant(d);
            if (d == 0) m_ptr[d] <= (mgrant(d) + 1) % N;
         end else if (m_valid[d] && out_ready) begin
            m_valid[d] <= 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk("model_ready", d, 32'(o_ready[d]), 32'(mready(d)));
         chk("model_valid", d, 32'(o_valid[d]), 32'(m_valid[d]));
         chk("model_data",  d, o_data[d], m_data[d]);
         chk("model_ch",    d, 32'(o_ch[d]), m_ch[d]);
      end
   end

   int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
   int wrap_seq [3] = '{0, 2, 0};

   initial begin
      rst = 1'b1;
      in_valid = '0;
      in_data = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;

      // reset then idle
      repeat (10) begin
         @(posedge clk); #2;
         for (int d = 0; d < 2; d++) begin
            chk("idle_valid", d, 32'(o_valid[d]), 0);
            chk("idle_ready", d, 32'(o_ready[d]), 0);
            chk("idle_data",  d, o_data[d], 0);
         end
      end

      // round-robin full load
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + i;
      in_valid = '1;
      #1 chk("lat_pre_valid", 0, 32'(o_valid[0]), 0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #2;
         chk("rr_ch",    0, 32'(o_ch[0]), rr_seq[k]);
         chk("rr_valid", 0, 32'(o_valid[0]), 1);
         chk("rr_data",  0, o_data[0], 32'hA0 + rr_seq[k]);
         chk("fp_ch",    1, 32'(o_ch[1]), 0);
      end

      // backpressure while holding the ch2 item
      @(posedge clk); #1;
      out_ready = 1'b0;
      #1 chk("bp_hold_ch", 0, 32'(o_ch[0]), 2);
      repeat (3) begin
         @(posedge clk); #2;
         chk("bp_ch",    0, 32'(o_ch[0]), 2);
         chk("bp_data",  0, o_data[0], 32'hA2);
         chk("bp_ready", 0, 32'(o_ready[0]), 0);
         chk("bp_valid", 0, 32'(o_valid[0]), 1);
      end
      out_ready = 1'b1;
      #1 chk("bp_refill_ready", 0, 32'(o_ready[0]), 32'h8);
      @(posedge clk); #2;
      chk("bp_next_ch",   0, 32'(o_ch[0]), 3);
      chk("bp_next_data", 0, o_data[0], 32'hA3);

      // fixed priority with ch1 and ch3 requesting
      in_valid = 4'b1010;
      repeat (4) begin
         @(posedge clk); #2;
         chk("fp_ch1", 1, 32'(o_ch[1]), 1);
         chk("fp_valid", 1, 32'(o_valid[1]), 1);
      end
      in_valid = 4'b1000;
      @(posedge clk); #2;
      chk("fp_ch3", 1, 32'(o_ch[1]), 3);
      chk("fp_data3", 1, o_data[1], 32'hA3);

      // pointer wrap, sparse requests
      rst = 1'b1;
      #1 rst = 1'b0;
      in_valid = 4'b0100;
      @(posedge clk); #2;
      chk("wrap_setup_ch", 0, 32'(o_ch[0]), 2);
      in_valid = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #2;
         chk("wrap_ch", 0, 32'(o_ch[0]), wrap_seq[k]);
      end

      // reset asserted mid-stall
      in_valid = '1;
      out_ready = 1'b0;
      @(posedge clk); #3;
      chk("stall_valid_pre", 0, 32'(o_valid[0]), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 0, 32'(o_valid[0]), 0);
      chk("async_rst_valid", 1, 32'(o_valid[1]), 0);
      chk("async_rst_data",  0, o_data[0], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      chk("post_rst_ch",    0, 32'(o_ch[0]), 0);
      chk("post_rst_valid", 0, 32'(o_valid[0]), 1);
      chk("post_rst_data",  0, o_data[0], 32'hA0);

      // randomized traffic, occasional reset pulses
      repeat (600) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 79) == 0);
         in_valid = N'($urandom);
         for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
